// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the shared-divider controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OP1_W = 16;
  localparam int OP2_W = 8;
  localparam int RES_W = 8;

  // Quotient reported for a divide-by-zero when the zero-divisor shortcut is built in
  localparam logic [RES_W-1:0] DIV0_RES = 8'hFF;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping past NREQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Rotating priority scan starting at ptr; the first hit wins
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Time-shares one external 16/8 divider between NREQ requesters, one transaction at a time.
// Latency: accept edge to rsp_valid is DIV_LAT+1 cycles (1 cycle for op2==0 with DIV_SHARE_DIV0_EN).
// Backpressure: req_ready is offered only in IDLE; requests are held by clients until accepted.
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*OP1_W-1:0] req_op1,
  input  logic [NREQ*OP2_W-1:0] req_op2,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [RES_W-1:0]      rsp_res,
`ifdef DIV_SHARE_DIV0_EN
  output logic                  rsp_div0,
`endif
  output logic                  busy,
  output logic [OP1_W-1:0]      div_op1,
  output logic [OP2_W-1:0]      div_op2,
  input  logic [RES_W-1:0]      div_res
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, owner, gidx, rr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  grant;
  logic             gany, accept, div0_hit;
  logic [OP1_W-1:0] win_op1;
  logic [OP2_W-1:0] win_op2;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Winner operand select, accept qualification and pointer advance
  always_comb begin
    win_op1   = req_op1[int'(gidx)*OP1_W +: OP1_W];
    win_op2   = req_op2[int'(gidx)*OP2_W +: OP2_W];
    accept    = (state == IDLE) && gany && !rst;
    req_ready = accept ? grant : '0;
    rr_nxt    = (gidx == IDX_W'(NREQ-1)) ? '0 : gidx + 1'b1;
`ifdef DIV_SHARE_DIV0_EN
    div0_hit  = (win_op2 == '0);
`else
    div0_hit  = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a zero divisor short-circuits straight to RESP when enabled
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div0_hit ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/owner capture, hold counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      div_op1   <= '0;
      div_op2   <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_res   <= '0;
`ifdef DIV_SHARE_DIV0_EN
      rsp_div0  <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
`ifdef DIV_SHARE_DIV0_EN
      rsp_div0  <= 1'b0;
`endif
      case (state)
        IDLE: if (accept) begin
          div_op1 <= win_op1;
          div_op2 <= win_op2;
          owner   <= gidx;
          cnt     <= CNT_W'(DIV_LAT-1);
          rr_ptr  <= rr_nxt;
          busy    <= 1'b1;
`ifdef DIV_SHARE_DIV0_EN
          if (div0_hit) begin
            rsp_res   <= DIV0_RES;
            rsp_valid <= grant;
            rsp_div0  <= 1'b1;
          end
`endif
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_res          <= div_res;
            rsp_valid[owner] <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider settling inside the hold window.
// Latency: checks accept-to-response spacing of DIV_LAT+1 (or 1 for the zero-divisor shortcut).
// Backpressure: client model holds req_valid until its accept handshake is seen.
module tb_div_share_ctrl;

  localparam int NREQ    = 4;
  localparam int DIV_LAT = 2;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*16-1:0] req_op1;
  logic [NREQ*8-1:0] req_op2;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_res;
  logic              busy;
  logic [15:0]       div_op1;
  logic [7:0]        div_op2;
  logic [7:0]        div_res;
`ifdef DIV_SHARE_DIV0_EN
  logic              rsp_div0;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int         acc_idx[$];
  int         acc_cyc[$];
  int         rsp_idx[$];
  int         rsp_cyc[$];
  logic [7:0] rsp_val[$];
  logic       rsp_bsy[$];
  logic       rsp_z[$];
  logic [NREQ-1:0] acc = '0;

  div_share_ctrl #(.NREQ(NREQ), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
`ifdef DIV_SHARE_DIV0_EN
    .rsp_div0  (rsp_div0),
`endif
    .busy      (busy),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .div_res   (div_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: one register stage, so the quotient is ready on the last hold cycle
  always @(posedge clk)
    div_res <= (div_op2 == 8'h00) ? 8'hA5 : 8'((div_op1 / {8'h00, div_op2}) & 16'h00FF);

  // Client model: drop a request bit right after the edge where it was accepted
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~acc;
  end

  // Monitor: log accepts and responses mid-cycle
  always @(negedge clk) begin
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        acc_idx.push_back(i);
        acc_cyc.push_back(cyc);
      end
      if (rsp_valid[i]) begin
        rsp_idx.push_back(i);
        rsp_cyc.push_back(cyc);
        rsp_val.push_back(rsp_res);
        rsp_bsy.push_back(busy);
`ifdef DIV_SHARE_DIV0_EN
        rsp_z.push_back(rsp_div0);
`else
        rsp_z.push_back(1'b0);
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int i, input logic [15:0] a, input logic [7:0] b);
    req_op1[i*16 +: 16] = a;
    req_op2[i*8 +: 8]   = b;
    req_valid[i]        = 1'b1;
  endtask

  task automatic clear_logs();
    acc_idx.delete(); acc_cyc.delete();
    rsp_idx.delete(); rsp_cyc.delete();
    rsp_val.delete(); rsp_bsy.delete(); rsp_z.delete();
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_idx.size() < n && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (rsp_idx.size() < n) chk("rsp_timeout", rsp_idx.size(), n);
  endtask

  logic [7:0] cont_exp [4] = '{8'h0A, 8'h33, 8'h80, 8'hC8};
  int         wrap_acc [3] = '{2, 3, 0};
  logic [7:0] wrap_exp [3] = '{8'h08, 8'h05, 8'h14};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_op1", div_op1, 0);
    chk("rst_div_op2", div_op2, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Contention: all four at once, served 0..3 four cycles apart
    clear_logs();
    post(0, 16'h0064, 8'h0A);
    post(1, 16'h00FF, 8'h05);
    post(2, 16'h0300, 8'h06);
    post(3, 16'h0FA0, 8'h14);
    wait_rsp(4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_acc%0d", k), acc_idx[k], k);
      chk($sformatf("cont_rsp%0d", k), rsp_idx[k], k);
      chk($sformatf("cont_res%0d", k), rsp_val[k], cont_exp[k]);
      chk($sformatf("cont_lat%0d", k), rsp_cyc[k] - acc_cyc[k], DIV_LAT + 1);
      chk($sformatf("cont_busy%0d", k), rsp_bsy[k], 1);
      if (k > 0) chk($sformatf("cont_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], DIV_LAT + 2);
    end

    // Single request
    step(); clear_logs();
    post(0, 16'h1111, 8'hAA);
    wait_rsp(1);
    chk("single_acc", acc_idx[0], 0);
    chk("single_rsp", rsp_idx[0], 0);
    chk("single_res", rsp_val[0], 8'h19);
    chk("single_lat", rsp_cyc[0] - acc_cyc[0], DIV_LAT + 1);

    // Round-robin wrap: grant 2, then 0 and 3 contend -> 3 first
    step(); clear_logs();
    post(2, 16'h0010, 8'h02);
    wait_rsp(1);
    step();
    post(0, 16'h00C8, 8'h0A);
    post(3, 16'h0050, 8'h10);
    wait_rsp(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap_acc%0d", k), acc_idx[k], wrap_acc[k]);
      chk($sformatf("wrap_res%0d", k), rsp_val[k], wrap_exp[k]);
    end

    // Quotient overflow passes through truncated
    step(); clear_logs();
    post(1, 16'hFFFF, 8'h01);
    wait_rsp(1);
    chk("ovf_ffff", rsp_val[0], 8'hFF);
    step(); clear_logs();
    post(1, 16'h1234, 8'h02);
    wait_rsp(1);
    chk("ovf_1234", rsp_val[0], 8'h1A);

    // Divide by zero
    step(); clear_logs();
    post(2, 16'h0064, 8'h00);
    wait_rsp(1);
`ifdef DIV_SHARE_DIV0_EN
    chk("div0_lat", rsp_cyc[0] - acc_cyc[0], 1);
    chk("div0_res", rsp_val[0], 8'hFF);
    chk("div0_flag", rsp_z[0], 1);
`else
    chk("div0_lat", rsp_cyc[0] - acc_cyc[0], DIV_LAT + 1);
    chk("div0_res", rsp_val[0], 8'hA5);
`endif
    @(negedge clk);
    chk("div0_op1", div_op1, 16'h0064);
    chk("div0_op2", div_op2, 8'h00);

    // Request raised and dropped while busy is never granted; idle outputs stay quiet
    step(); clear_logs();
    post(0, 16'h0100, 8'h10);
    step();
    req_op1[16 +: 16] = 16'h4444;
    req_op2[8 +: 8]   = 8'h44;
    req_valid[1]      = 1'b1;
    step();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    repeat (5) step();
    @(negedge clk);
    chk("idle_res", rsp_val[0], 8'h10);
    chk("idle_nacc", acc_idx.size(), 1);
    chk("idle_nrsp", rsp_idx.size(), 1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 0);
    chk("idle_rspv", rsp_valid, 0);
    chk("idle_op1", div_op1, 16'h0100);
    chk("idle_op2", div_op2, 8'h10);

    // Reset during WAIT aborts without a response
    step(); clear_logs();
    post(3, 16'h2222, 8'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_op1", div_op1, 0);
    chk("abort_op2", div_op2, 0);
    chk("abort_res", rsp_res, 0);
    repeat (6) step();
    chk("abort_nrsp", rsp_idx.size(), 0);
    chk("abort_nacc", acc_idx.size(), 1);
    clear_logs();
    post(1, 16'h0090, 8'h0C);
    wait_rsp(1);
    chk("post_rst_acc", acc_idx[0], 1);
    chk("post_rst_res", rsp_val[0], 8'h0C);
    chk("post_rst_lat", rsp_cyc[0] - acc_cyc[0], DIV_LAT + 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Time-shares one divider16bit8 instance (16-bit dividend, 8-bit divisor, 8-bit quotient) between NREQ requesters.
- Arbitration is round-robin. Accepted operands are registered and held stable on the divider inputs for DIV_LAT cycles, then the quotient is sampled and returned to the winning requester.
- Sits between client blocks and the single divider datapath; the divider itself is unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DIV_LAT, 2, cycles the divider inputs are held before div_res is sampled (>=1).
- CNT_W, 3, width of the latency counter; must hold DIV_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request strobe per requester; held until accepted.
- req_op1  in  NREQ*16  dividends, requester i at bits [16i+15:16i].
- req_op2  in  NREQ*8  divisors, requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot one-cycle result pulse.
- rsp_res  out  8  quotient; valid only while any rsp_valid bit is high.
- busy  out  1  high from accept until the rsp cycle inclusive.
- div_op1  out  16  to divider op1.
- div_op2  out  8  to divider op2.
- div_res  in  8  from divider res.

Behaviour:
- Reset (rst high at a clk edge), all outputs: req_ready=0, rsp_valid=0, rsp_res=0, busy=0, div_op1=0, div_op2=0. State=IDLE, rr pointer=0, counter=0. Reset mid-operation aborts the transaction; no rsp is issued.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the rr pointer upward with wrap.
  - The grant drives req_ready[g]=1 combinationally in the same cycle (handshake = req_valid & req_ready).
  - At the edge: div_op1/div_op2 <= winner operands, owner <= g, counter <= DIV_LAT-1, rr pointer <= (g+1) mod NREQ, state -> WAIT, busy <= 1.
  - With no req_valid set, stay in IDLE.
- WAIT:
  - Operands are held constant and req_ready=0 for all requesters.
  - The counter decrements each cycle. When it is 0: rsp_res <= div_res, rsp_valid[owner] <= 1, state -> RESP.
- RESP:
  - rsp_valid is high for exactly this one cycle, and busy is high. The next state is IDLE.
  - Arbitration is not performed in RESP; the earliest next accept is the following cycle.
- Latency: accept edge to rsp_valid rising is DIV_LAT+1 cycles. Minimum back-to-back spacing is DIV_LAT+2 cycles.
- Fairness: a requester holding req_valid is served within NREQ transactions.
- A requester dropping req_valid before accept is legal; the request is simply not granted.
- Quotient overflow (op1/op2 > 255): the divider's 8-bit result passes through unmodified.
- req_valid changing during WAIT/RESP is ignored until IDLE.
- Only one transaction is outstanding at a time; there is no queueing.

Optional Feature:
- Macro DIV_SHARE_DIV0_EN.
- Defined:
  - An accepted request with op2==0 skips WAIT and goes directly to RESP with rsp_res=8'hFF.
  - Extra output port rsp_div0 (1 bit) is high alongside rsp_valid for that response.
  - div_op1/div_op2 are still loaded.
  - Latency for this case is 1 cycle.
- Undefined: no rsp_div0 port; op2==0 is processed normally and the divider output is returned as-is.

Decomposition:
- Package div_ctrl_pkg:
  - state enum {IDLE, WAIT, RESP};
  - OP1_W=16, OP2_W=8, RES_W=8;
  - DIV0_RES=8'hFF.
- Sub-module rr_arbiter (NREQ): inputs req, pointer; output one-hot grant plus grant index.
- The div_share_ctrl top holds the FSM, operand/owner registers and counter.
- The divider16bit8 instance lives outside this block, wired by the integrator.

Test Plan (NREQ=4, DIV_LAT=2, a divider model with 2-cycle latency):
- Single request: requester 0 with op1=16'h1111, op2=8'hAA -> req_ready[0] in cycle 0; rsp_valid=4'b0001, rsp_res=8'h19 at cycle 3.
- Contention: all four requesters valid simultaneously with distinct operands -> grants in order 0,1,2,3, each 4 cycles apart. Example: req1 op1=16'h00FF, op2=5 -> rsp_res=8'h33.
- Round-robin wrap: last grant was to requester 2, then requesters 0 and 3 are both valid -> grant 3 before 0.
- Reset mid-operation: rst asserted during WAIT -> no rsp_valid afterwards, all outputs 0; a new request after reset is served normally.
- Divide by zero, with DIV_SHARE_DIV0_EN: op1=16'h0064, op2=0 -> next cycle rsp_res=8'hFF, rsp_div0=1. Without the macro: the divider output is forwarded at the normal latency.
- Idle hold: req_valid dropped before grant, or no requests -> req_ready, rsp_valid and busy stay 0; div_op1/div_op2 keep their last values.
